bcd_serial_subtractor: RTL and testbench

- Digit-serial multi-digit BCD subtractor: computes A − B one BCD digit per clock, least-significant digit (LSD) first, using ten's-complement addition with BCD correction.
- Produces a sign-magnitude result: BCD magnitude plus a negative flag.
- Companion to the combinational BCD adder in the arithmetic datapath, for wide operands where area matters more than latency.
- Start/done handshake to the controlling logic.

---
 rtl/bcd_serial_subtractor_if.sv | 24 ++
 rtl/bcd_serial_subtractor.sv | 235 +++++++++++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the digit-serial BCD subtractor.
// The controller drives the master side and the subtractor sits on the slave side.
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  invalid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, a, b,
    input  diff, neg, invalid, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, neg, invalid, busy, done
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B one digit per clock, LSD first, by ten's-complement
// addition; a negative raw result is re-complemented in a second pass to give sign-magnitude.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_serial_subtractor_if.slave   bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_raw;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_diff;
  logic               r_neg;
  logic               r_invalid;
  logic               r_busy;
  logic               r_done;

  logic               w_bad;
  logic               w_last;
  logic [4:0]         w_digit;
  logic [3:0]         w_op_x;
  logic [3:0]         w_op_y;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [W-1:0]       w_res_diff;
  logic               w_res_neg;
  logic               w_res_inv;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      bad = bad | (v[4*k +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // {carry_out, digit} of x + (9 - y) + cin with BCD correction; FIX uses x = 0.
  function automatic logic [4:0] sub_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    logic [4:0] s;
    logic [4:0] r;
    s = {1'b0, x} + {1'b0, 4'd9 - y} + {4'd0, cin};
    if (s > 5'd9) begin
      r    = s - 5'd10;
      r[4] = 1'b1;
    end else begin
      r    = s;
      r[4] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] vec, input logic [3:0] d);
    logic [W-1:0] tmp;
    tmp           = vec >> 3'd4;
    tmp[W-1 -: 4] = d;
    return tmp;
  endfunction

  assign w_bad   = has_bad_digit(bus.a) | has_bad_digit(bus.b);
  assign w_last  = (r_idx == IDX_LAST);
  assign w_op_x  = (r_state == S_FIX) ? 4'd0 : r_a[3:0];
  assign w_op_y  = (r_state == S_FIX) ? r_raw[3:0] : r_b[3:0];
  assign w_digit = sub_digit(w_op_x, w_op_y, r_carry);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_next_state = w_bad ? S_DONE : S_SUB;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SUB: begin
        if (w_last) begin
          w_next_state = w_digit[4] ? S_DONE : S_FIX;
        end else begin
          w_next_state = S_SUB;
        end
      end
      S_FIX: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FIX;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output/result values to be registered on this edge
  always_comb begin
    w_busy_nxt = (w_next_state == S_SUB) || (w_next_state == S_FIX);
    w_done_nxt = (w_next_state == S_DONE);
    w_res_diff = r_diff;
    w_res_neg  = r_neg;
    w_res_inv  = r_invalid;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start && w_bad) begin
          w_res_diff = {W{1'b0}};
          w_res_neg  = 1'b0;
          w_res_inv  = 1'b1;
        end else begin
          w_res_diff = r_diff;
        end
      end
      S_SUB: begin
        // Carry out of the top digit means A >= B, so the raw sum is already the magnitude.
        if (w_last && w_digit[4]) begin
          w_res_diff = shift_in(r_raw, w_digit[3:0]);
          w_res_neg  = 1'b0;
          w_res_inv  = 1'b0;
        end else begin
          w_res_diff = r_diff;
        end
      end
      S_FIX: begin
        if (w_last) begin
          w_res_diff = shift_in(r_raw, w_digit[3:0]);
          w_res_neg  = 1'b1;
          w_res_inv  = 1'b0;
        end else begin
          w_res_diff = r_diff;
        end
      end
      default: w_res_diff = r_diff;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff    <= {W{1'b0}};
      r_neg     <= 1'b0;
      r_invalid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_diff    <= w_res_diff;
      r_neg     <= w_res_neg;
      r_invalid <= w_res_inv;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Working registers: operands shift out LSD first, result digits shift in at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_raw   <= {W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_raw   <= {W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_carry <= 1'b1;
          end else begin
            r_carry <= r_carry;
          end
        end
        S_SUB: begin
          r_a   <= r_a >> 3'd4;
          r_b   <= r_b >> 3'd4;
          r_raw <= shift_in(r_raw, w_digit[3:0]);
          if (w_last) begin
            r_idx   <= {IDX_W{1'b0}};
            r_carry <= 1'b1;
          end else begin
            r_idx   <= r_idx + IDX_ONE;
            r_carry <= w_digit[4];
          end
        end
        S_FIX: begin
          r_raw   <= shift_in(r_raw, w_digit[3:0]);
          r_carry <= w_digit[4];
          if (w_last) begin
            r_idx <= {IDX_W{1'b0}};
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        default: begin
          r_idx <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.diff    = r_diff;
  assign bus.neg     = r_neg;
  assign bus.invalid = r_invalid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: vector table plus random operands,
// expected results queued at start and compared when done pulses.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();
  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] diff;
    logic         neg;
    logic         inv;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
    int           lat;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  res_t sb_q[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: convert to integers, subtract, convert back.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int ia, ib, d, p;
    r.diff = '0; r.neg = 1'b0; r.inv = 1'b0;
    ia = 0; ib = 0; p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) r.inv = 1'b1;
      ia += int'(a[4*k +: 4]) * p;
      ib += int'(b[4*k +: 4]) * p;
      p  *= 10;
    end
    if (!r.inv) begin
      d     = ia - ib;
      r.neg = (d < 0);
      if (d < 0) d = -d;
      for (int k = 0; k < DIGITS; k++) begin
        r.diff[4*k +: 4] = 4'(d % 10);
        d = d / 10;
      end
    end
    return r;
  endfunction

  task automatic compare_popped(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_sb: done with empty scoreboard", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_diff"}, 32'(bus.diff), 32'(e.diff));
      chk({tag, "_neg"}, 32'(bus.neg), 32'(e.neg));
      chk({tag, "_inv"}, 32'(bus.invalid), 32'(e.inv));
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input res_t exp, input int lat, input string tag);
    int cyc;
    bit got;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    sb_q.push_back(exp);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 3 * DIGITS + 4) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      if (bus.done) got = 1'b1;
      else chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no done after %0d cycles", tag, cyc);
      void'(sb_q.pop_back());
    end else begin
      chk({tag, "_latency"}, 32'(cyc), 32'(lat));
      compare_popped(tag);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_diff_hold"}, 32'(bus.diff), 32'(exp.diff));
    end
  endtask

  initial begin
    vecs[0] = '{16'h4321, 16'h1234, '{16'h3087, 1'b0, 1'b0}, 5};
    vecs[1] = '{16'h1234, 16'h4321, '{16'h3087, 1'b1, 1'b0}, 9};
    vecs[2] = '{16'h0000, 16'h9999, '{16'h9999, 1'b1, 1'b0}, 9};
    vecs[3] = '{16'h5555, 16'h5555, '{16'h0000, 1'b0, 1'b0}, 5};
    vecs[4] = '{16'h9999, 16'h0000, '{16'h9999, 1'b0, 1'b0}, 5};
    vecs[5] = '{16'h1000, 16'h0001, '{16'h0999, 1'b0, 1'b0}, 5};
    vecs[6] = '{16'h12A4, 16'h0001, '{16'h0000, 1'b0, 1'b1}, 1};
    vecs[7] = '{16'h0010, 16'h0001, '{16'h0009, 1'b0, 1'b0}, 5};
    vecs[8] = '{16'h0001, 16'h1000, '{16'h0999, 1'b1, 1'b0}, 9};
    vecs[9] = '{16'h0000, 16'h000F, '{16'h0000, 1'b0, 1'b1}, 1};

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #1;
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_inv", 32'(bus.invalid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      res_t         e;
      for (int k = 0; k < DIGITS; k++) begin
        ra[4*k +: 4] = 4'($urandom_range(9, 0));
        rb[4*k +: 4] = 4'($urandom_range(9, 0));
      end
      e = model(ra, rb);
      run_op(ra, rb, e, e.neg ? 2 * DIGITS + 1 : DIGITS + 1, $sformatf("rnd%0d", i));
    end

    // start held high: operands change mid-op, second op launches straight from DONE
    begin
      int ndone;
      int dcyc[2];
      ndone = 0; dcyc[0] = -1; dcyc[1] = -1;
      @(negedge clk);
      bus.a = 16'h4321; bus.b = 16'h1234; bus.start = 1'b1;
      sb_q.push_back('{16'h3087, 1'b0, 1'b0});
      sb_q.push_back('{16'h0009, 1'b0, 1'b0});
      for (int cyc = 1; cyc <= 14; cyc++) begin
        @(posedge clk); #1;
        if (cyc == 1) begin
          bus.a = 16'h0010; bus.b = 16'h0001;
        end
        if (cyc == 6) begin
          bus.start = 1'b0;
          chk("b2b_diff_hold", 32'(bus.diff), 32'h3087);
          chk("b2b_busy", 32'(bus.busy), 32'd1);
        end
        if (bus.done) begin
          if (ndone < 2) dcyc[ndone] = cyc;
          ndone++;
          compare_popped($sformatf("b2b%0d", ndone));
        end
      end
      chk("b2b_done_count", 32'(ndone), 32'd2);
      chk("b2b_first_done", 32'(dcyc[0]), 32'd5);
      chk("b2b_second_done", 32'(dcyc[1]), 32'd10);
      while (sb_q.size() > 0) void'(sb_q.pop_front());
    end

    // asynchronous reset in cycle 2 of an operation
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1234; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_diff", 32'(bus.diff), 32'd0);
    chk("arst_neg", 32'(bus.neg), 32'd0);
    chk("arst_inv", 32'(bus.invalid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", 32'(bus.done), 32'd0);
    end
    run_op(16'h4321, 16'h1234, '{16'h3087, 1'b0, 1'b0}, 5, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
